// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the access sequencer (master) and the memory (slave).
interface mem_access_ctrl_if;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [3:0]  Mem_BE;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData;
    logic        Mem_Ready;

    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_BE, Mem_WData,
        input  Mem_RData, Mem_Ready
    );

    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_BE, Mem_WData,
        output Mem_RData, Mem_Ready
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: turns pipeline memory requests into a word-aligned
// handshake with byte enables, stalling the pipeline across wait states.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 Byte_Op,
    input  logic [31:0]          Address,
    input  logic [31:0]          Write_data,
    output logic [31:0]          Read_data,
    output logic                 Load_Select,
    output logic [1:0]           Offset,
    output logic                 Stall,
    output logic                 Access_Err,
    mem_access_ctrl_if.master    mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [31:0] addrQ, addrD;
    logic [31:0] wdataQ, wdataD;
    logic        byteQ, byteD;
    logic        writeQ, writeD;
    logic        errQ, errD;
    logic [31:0] rdataQ, rdataD;
    logic [1:0]  offQ, offD;
    logic        lselQ, lselD;
    logic        reqActive;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
            byteQ  <= 1'b0;
            writeQ <= 1'b0;
            errQ   <= 1'b0;
            rdataQ <= '0;
            offQ   <= '0;
            lselQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            addrQ  <= addrD;
            wdataQ <= wdataD;
            byteQ  <= byteD;
            writeQ <= writeD;
            errQ   <= errD;
            rdataQ <= rdataD;
            offQ   <= offD;
            lselQ  <= lselD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        addrD  = addrQ;
        wdataD = wdataQ;
        byteD  = byteQ;
        writeD = writeQ;
        errD   = 1'b0;
        rdataD = rdataQ;
        offD   = offQ;
        lselD  = lselQ;
        Stall  = 1'b0;

        case (stateQ)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    Stall  = 1'b1;
                    addrD  = Address;
                    wdataD = Write_data;
                    byteD  = Byte_Op;
                    writeD = MemWrite;
                    cntD   = '0;
                    // Conflicting or misaligned requests never reach the memory.
                    if ((MemRead && MemWrite) || (!Byte_Op && (Address[1:0] != 2'b00))) begin
                        errD   = 1'b1;
                        stateD = DONE;
                    end else begin
                        stateD = REQ;
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (mem.Mem_Ready) begin
                    if (!writeQ) begin
                        rdataD = mem.Mem_RData;
                        offD   = addrQ[1:0];
                        lselD  = byteQ;
                    end
                    cntD   = '0;
                    stateD = DONE;
                end else if (cntQ == CNT_W'(TIMEOUT - 1)) begin
                    errD = 1'b1;
                    if (!writeQ) begin
                        rdataD = '0;
                        offD   = addrQ[1:0];
                        lselD  = byteQ;
                    end
                    cntD   = '0;
                    stateD = DONE;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            DONE: begin
                // Requests still visible here are the completed ones; drop them.
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign reqActive = (stateQ == REQ);

    always_comb begin
        mem.Mem_Req   = reqActive;
        mem.Mem_We    = 1'b0;
        mem.Mem_Addr  = '0;
        mem.Mem_BE    = '0;
        mem.Mem_WData = '0;
        if (reqActive) begin
            mem.Mem_We   = writeQ;
            mem.Mem_Addr = {addrQ[31:2], 2'b00};
            if (byteQ) begin
                mem.Mem_BE    = 4'b0001 << addrQ[1:0];
                mem.Mem_WData = {4{wdataQ[7:0]}};
            end else begin
                mem.Mem_BE    = 4'b1111;
                mem.Mem_WData = wdataQ;
            end
        end
    end

    assign Read_data   = rdataQ;
    assign Offset      = offQ;
    assign Load_Select = lselQ;
    assign Access_Err  = errQ;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed cycle-by-cycle vectors for mem_access_ctrl, plus reset-mid-access
// and timeout sequences.
module tb_mem_access_ctrl;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic        bop;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] rdat;
        logic        eReq;
        logic        eWe;
        logic [31:0] eAddr;
        logic [3:0]  eBe;
        logic [31:0] eWdata;
        logic        eStall;
        logic        eErr;
        logic [31:0] eRdata;
        logic [1:0]  eOff;
        logic        eLsel;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        Byte_Op;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        Load_Select;
    logic [1:0]  Offset;
    logic        Stall;
    logic        Access_Err;

    int compared;
    int mismatched;
    int vecIdx;

    mem_access_ctrl_if memIf ();

    mem_access_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Byte_Op     (Byte_Op),
        .Address     (Address),
        .Write_data  (Write_data),
        .Read_data   (Read_data),
        .Load_Select (Load_Select),
        .Offset      (Offset),
        .Stall       (Stall),
        .Access_Err  (Access_Err),
        .mem         (memIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic rst, rd, wr, bop,
        input logic [31:0] addr, wdata,
        input logic rdy,
        input logic [31:0] rdat,
        input logic eReq, eWe,
        input logic [31:0] eAddr,
        input logic [3:0] eBe,
        input logic [31:0] eWdata,
        input logic eStall, eErr,
        input logic [31:0] eRdata,
        input logic [1:0] eOff,
        input logic eLsel
    );
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.bop = bop;
        v.addr = addr; v.wdata = wdata; v.rdy = rdy; v.rdat = rdat;
        v.eReq = eReq; v.eWe = eWe; v.eAddr = eAddr; v.eBe = eBe;
        v.eWdata = eWdata; v.eStall = eStall; v.eErr = eErr;
        v.eRdata = eRdata; v.eOff = eOff; v.eLsel = eLsel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL vec %0d %s: got %h expected %h", vecIdx, name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset                = v.rst;
        MemRead              = v.rd;
        MemWrite             = v.wr;
        Byte_Op              = v.bop;
        Address              = v.addr;
        Write_data           = v.wdata;
        memIf.Mem_Ready      = v.rdy;
        memIf.Mem_RData      = v.rdat;
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        chk("Mem_Req",     {31'b0, memIf.Mem_Req}, {31'b0, v.eReq});
        chk("Stall",       {31'b0, Stall},         {31'b0, v.eStall});
        chk("Access_Err",  {31'b0, Access_Err},    {31'b0, v.eErr});
        chk("Read_data",   Read_data,              v.eRdata);
        chk("Offset",      {30'b0, Offset},        {30'b0, v.eOff});
        chk("Load_Select", {31'b0, Load_Select},   {31'b0, v.eLsel});
        if (v.eReq) begin
            chk("Mem_We",    {31'b0, memIf.Mem_We}, {31'b0, v.eWe});
            chk("Mem_Addr",  memIf.Mem_Addr,        v.eAddr);
            chk("Mem_BE",    {28'b0, memIf.Mem_BE}, {28'b0, v.eBe});
            chk("Mem_WData", memIf.Mem_WData,       v.eWdata);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
        vecIdx++;
    endtask

    vec_t vecs[$];

    initial begin
        compared        = 0;
        mismatched      = 0;
        vecIdx          = 0;
        reset           = 1'b1;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        Byte_Op         = 1'b0;
        Address         = '0;
        Write_data      = '0;
        memIf.Mem_Ready = 1'b0;
        memIf.Mem_RData = '0;

        //                  rst rd wr bo addr        wdata         rdy rdat          | req we eAddr       be    eWdata        stl err eRdata        off ls
        vecs.push_back(mkVec(1, 0, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        0, 0, 32'h0,        0, 0));
        // word load 0x100, two wait states
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h100,    32'h0,        0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        1, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h100,    32'h0,        0, 32'h0,        1, 0, 32'h100,    4'hF, 32'h0,        1, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h100,    32'h0,        0, 32'h0,        1, 0, 32'h100,    4'hF, 32'h0,        1, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h100,    32'h0,        1, 32'hDEADBEEF, 1, 0, 32'h100,    4'hF, 32'h0,        1, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h100,    32'h0,        1, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 0));
        // byte load 0x203, zero wait, issued right after DONE
        vecs.push_back(mkVec(0, 1, 0, 1, 32'h203,    32'h0,        0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 1, 32'h203,    32'h0,        1, 32'h11223344, 1, 0, 32'h200,    4'h8, 32'h0,        1, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 1, 32'h203,    32'h0,        0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        0, 0, 32'h11223344, 3, 1));
        // byte store 0x302, one wait state; returned data must be ignored
        vecs.push_back(mkVec(0, 0, 1, 1, 32'h302,    32'hA5,       0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        1, 0, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 0, 1, 1, 32'h302,    32'hA5,       0, 32'h0,        1, 1, 32'h300,    4'h4, 32'hA5A5A5A5, 1, 0, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 0, 1, 1, 32'h302,    32'hA5,       1, 32'hCAFEF00D, 1, 1, 32'h300,    4'h4, 32'hA5A5A5A5, 1, 0, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 0, 1, 1, 32'h302,    32'hA5,       0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        0, 0, 32'h11223344, 3, 1));
        // misaligned word load
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h101,    32'h0,        0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        1, 0, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h101,    32'h0,        0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        0, 1, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        0, 0, 32'h11223344, 3, 1));
        // read/write conflict, with a stray Mem_Ready outside REQ
        vecs.push_back(mkVec(0, 1, 1, 1, 32'h400,    32'h0,        1, 32'h55,       0, 0, 32'h0,      4'h0, 32'h0,        1, 0, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 1, 1, 1, 32'h400,    32'h0,        1, 32'h55,       0, 0, 32'h0,      4'h0, 32'h0,        0, 1, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,      32'h0,        1, 32'h66,       0, 0, 32'h0,      4'h0, 32'h0,        0, 0, 32'h11223344, 3, 1));
        // word store 0x404, zero wait
        vecs.push_back(mkVec(0, 0, 1, 0, 32'h404,    32'h12345678, 1, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        1, 0, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 0, 1, 0, 32'h404,    32'h12345678, 1, 32'h77,       1, 1, 32'h404,    4'hF, 32'h12345678, 1, 0, 32'h11223344, 3, 1));
        vecs.push_back(mkVec(0, 0, 1, 0, 32'h404,    32'h12345678, 0, 32'h0,        0, 0, 32'h0,      4'h0, 32'h0,        0, 0, 32'h11223344, 3, 1));

        foreach (vecs[i]) runVec(vecs[i]);

        $display("[TB] reset during REQ");
        runVec(mkVec(0, 1, 0, 0, 32'h600, 32'h0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 32'h11223344, 3, 1));
        runVec(mkVec(0, 1, 0, 0, 32'h600, 32'h0, 0, 32'h0,        1, 0, 32'h600, 4'hF, 32'h0, 1, 0, 32'h11223344, 3, 1));
        runVec(mkVec(1, 0, 0, 0, 32'h0,   32'h0, 0, 32'h0,        1, 0, 32'h600, 4'hF, 32'h0, 1, 0, 32'h11223344, 3, 1));
        runVec(mkVec(0, 0, 0, 0, 32'h0,   32'h0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 32'h0,        0, 0));
        runVec(mkVec(0, 1, 0, 0, 32'h700, 32'h0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 32'h0,        0, 0));
        runVec(mkVec(0, 1, 0, 0, 32'h700, 32'h0, 1, 32'h12345678, 1, 0, 32'h700, 4'hF, 32'h0, 1, 0, 32'h0,        0, 0));
        runVec(mkVec(0, 0, 0, 0, 32'h0,   32'h0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 32'h12345678, 0, 0));

        $display("[TB] timeout on byte load 0x502");
        runVec(mkVec(0, 1, 0, 1, 32'h502, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h12345678, 0, 0));
        for (int c = 0; c < 16; c++) begin
            runVec(mkVec(0, 1, 0, 1, 32'h502, 32'h0, 0, 32'h0, 1, 0, 32'h500, 4'h4, 32'h0, 1, 0, 32'h12345678, 0, 0));
        end
        runVec(mkVec(0, 1, 0, 1, 32'h502, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0, 2, 1));
        runVec(mkVec(0, 0, 0, 0, 32'h0,   32'h0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 2, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Data-memory access sequencer sitting between the EX/MEM pipeline signals and the data memory.
- Converts load/store requests into a word-aligned memory handshake with byte enables.
- Stalls the pipeline across memory wait states.
- Hands the returned word, byte offset and byte/word select downstream to the load byte-extraction stage (Read_data, Offset, Load_Select).

Parameters:
TIMEOUT, 16, max cycles Mem_Req may stay high without Mem_Ready before the access is aborted (valid range 2..255)
CNT_W, 8, width of the wait-state counter; must hold TIMEOUT

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
MemRead  input  1  load request from pipeline, held stable while Stall=1
MemWrite  input  1  store request from pipeline, held stable while Stall=1
Byte_Op  input  1  1 = byte access, 0 = word access
Address  input  32  byte address from ALU
Write_data  input  32  store data (byte stores use bits [7:0])
Mem_Req  output  1  memory request, held until Mem_Ready
Mem_We  output  1  1 = write cycle, valid while Mem_Req=1
Mem_Addr  output  32  {Address[31:2],2'b00}, valid while Mem_Req=1
Mem_BE  output  4  byte enables, valid while Mem_Req=1
Mem_WData  output  32  write data, valid while Mem_Req=1
Mem_RData  input  32  memory read word, sampled when Mem_Req and Mem_Ready
Mem_Ready  input  1  memory completion strobe
Read_data  output  32  registered read word to load stage
Load_Select  output  1  registered Byte_Op of last load (1 = byte)
Offset  output  2  registered Address[1:0] of last load
Stall  output  1  pipeline freeze
Access_Err  output  1  one-cycle pulse on misalignment, conflict or timeout

Behaviour:
- Reset (sync, dominates everything, including mid-access): state IDLE, counter 0, all outputs 0, Read_data=0.
- Reset mid-access drops Mem_Req the following cycle with no completion. The memory must tolerate an abandoned request.
- States: IDLE, REQ, DONE.
- IDLE, no request: Stall=0, Mem_Req=0.
- IDLE, MemRead or MemWrite seen:
  - Latch Address, Write_data, Byte_Op and type into internal registers.
  - Stall=1 combinationally in the same cycle.
  - Next state REQ.
- Error cases in IDLE (checked before the REQ transition):
  - Both MemRead and MemWrite high: conflict.
  - Word access with Address[1:0]!=0: misalignment.
  - Either case: no memory cycle, Access_Err=1 registered, next state DONE, Read_data unchanged.
- REQ:
  - Mem_Req=1; Mem_We=1 for a store.
  - Word access: Mem_BE=4'b1111, Mem_WData=Write_data.
  - Byte access: Mem_BE=4'b0001<<Address[1:0], Mem_WData={4{Write_data[7:0]}}.
  - Counter increments each cycle without Mem_Ready.
  - Mem_Ready=1: for a load, Read_data<=Mem_RData, Offset<=Address[1:0], Load_Select<=Byte_Op. Next state DONE, counter cleared.
  - Counter reaches TIMEOUT-1 with no Mem_Ready: Access_Err pulse, Read_data<=0, Offset and Load_Select still updated for a load. Next state DONE.
  - Stall=1 throughout REQ.
- DONE:
  - Stall=0 for exactly one cycle so the pipeline advances. Mem_Req=0.
  - Next state IDLE unconditionally. Requests present in DONE are the old, completed ones and are ignored.
  - A new request is accepted in the following IDLE cycle.
- Zero-wait memory (Mem_Ready in the first REQ cycle): Stall high 2 cycles, DONE in cycle 2. Minimum access latency 3 cycles, throughput 1 access per 3 cycles.
- Read_data, Offset and Load_Select hold their values until the next completed load. Stores never modify them.
- Mem_Ready outside REQ is ignored.
- Access_Err is high only in the first DONE cycle.

Test Plan:
- Word load, Address=0x100, Mem_Ready after 2 wait cycles, Mem_RData=0xDEADBEEF -> Mem_Addr=0x100, Mem_BE=1111, Stall high 4 cycles, DONE: Read_data=0xDEADBEEF, Offset=0, Load_Select=0.
- Byte load, Address=0x203, zero-wait, Mem_RData=0x11223344 -> Mem_Addr=0x200, Stall 2 cycles, Offset=3, Load_Select=1, Read_data=0x11223344.
- Byte store, Address=0x302, Write_data=0x000000A5 -> Mem_We=1, Mem_BE=0100, Mem_WData=0xA5A5A5A5. Read_data unchanged afterwards.
- Word load at Address=0x101, and separately MemRead=MemWrite=1 -> no Mem_Req, Access_Err pulse 1 cycle, Stall high 1 cycle, then DONE.
- Load with Mem_Ready never asserted, TIMEOUT=16 -> Mem_Req high 16 cycles, then Access_Err=1, Read_data=0, Stall released.
- reset asserted during REQ -> next cycle Mem_Req=0, Stall=0, Read_data=0. A fresh load then completes normally.
